// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, register/select encodings and ALU operation codes
package cpu_pkg;
    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;
    localparam logic [AW-1:0] REG_ZERO = 5'd0;
    localparam logic SRC_REG  = 1'b0;
    localparam logic SRC_IMM  = 1'b1;
    localparam logic EXT_ZERO = 1'b0;
    localparam logic EXT_SIGN = 1'b1;
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0100;
endpackage

// File: rtl/reg_file.sv
// reg_file: NREG x DW register file, async reset, one write port, two
// write-first bypassed read ports and an unbypassed debug read port.
// Ports: clk/rst; rs/rt read addresses -> rd_a/rd_b; we/wa/wd write port;
// dbg_addr -> dbg_data (storage only).
module reg_file
    import cpu_pkg::*;
#(
    parameter int DW   = cpu_pkg::DW,
    parameter int NREG = cpu_pkg::NREG,
    parameter int AW   = cpu_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] rt,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] rd_a,
    output logic [DW-1:0] rd_b,
    output logic [DW-1:0] dbg_data
);
    logic [DW-1:0] regs_q [NREG];
    logic          hit_a, hit_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (we && wa != REG_ZERO) begin
            regs_q[wa] <= wd;
        end
    end

    // Bypass compares run in parallel with the storage mux, not through it.
    assign hit_a    = we && wa == rs;
    assign hit_b    = we && wa == rt;
    assign rd_a     = rs == REG_ZERO ? '0 : hit_a ? wd : regs_q[rs];
    assign rd_b     = rt == REG_ZERO ? '0 : hit_b ? wd : regs_q[rt];
    assign dbg_data = dbg_addr == REG_ZERO ? '0 : regs_q[dbg_addr];
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: register file plus immediate extender and B-operand mux
// feeding the ALU.
// Ports: clk/rst; rs/rt register reads; imm16/ExtOp immediate; ALUSrc B
// select; RegWrite/WriteReg/WriteData writeback; A/B ALU operands;
// rt_data store data; dbg_addr/dbg_data unbypassed debug read.
module operand_fetch
    import cpu_pkg::*;
#(
    parameter int DW   = cpu_pkg::DW,
    parameter int NREG = cpu_pkg::NREG,
    parameter int AW   = cpu_pkg::AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AW-1:0]        rs,
    input  logic [AW-1:0]        rt,
    input  logic [15:0]          imm16,
    input  logic                 ExtOp,
    input  logic                 ALUSrc,
    input  logic                 RegWrite,
    input  logic [AW-1:0]        WriteReg,
    input  logic [DW-1:0]        WriteData,
    output logic signed [DW-1:0] A,
    output logic signed [DW-1:0] B,
    output logic [DW-1:0]        rt_data,
    input  logic [AW-1:0]        dbg_addr,
    output logic [DW-1:0]        dbg_data
);
    logic [DW-1:0] rd_a, rd_b, ext;

    reg_file #(.DW(DW), .NREG(NREG), .AW(AW)) u_rf (
        .clk      (clk),
        .rst      (rst),
        .rs       (rs),
        .rt       (rt),
        .we       (RegWrite),
        .wa       (WriteReg),
        .wd       (WriteData),
        .dbg_addr (dbg_addr),
        .rd_a     (rd_a),
        .rd_b     (rd_b),
        .dbg_data (dbg_data)
    );

    assign ext     = ExtOp == EXT_SIGN ? {{(DW-16){imm16[15]}}, imm16} : {{(DW-16){1'b0}}, imm16};
    assign A       = rd_a;
    assign rt_data = rd_b;
    assign B       = ALUSrc == SRC_IMM ? ext : rd_b;
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed self-checking bench for operand_fetch
module tb_operand_fetch;
    logic        clk = 0, rst = 0;
    logic [4:0]  rs = 0, rt = 0, WriteReg = 0, dbg_addr = 0;
    logic [15:0] imm16 = 0;
    logic        ExtOp = 0, ALUSrc = 0, RegWrite = 0;
    logic [31:0] WriteData = 0;
    logic signed [31:0] A, B;
    logic [31:0] rt_data, dbg_data;
    int checks = 0, errors = 0;

    operand_fetch dut (
        .clk(clk), .rst(rst), .rs(rs), .rt(rt), .imm16(imm16), .ExtOp(ExtOp),
        .ALUSrc(ALUSrc), .RegWrite(RegWrite), .WriteReg(WriteReg),
        .WriteData(WriteData), .A(A), .B(B), .rt_data(rt_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] d);
        RegWrite = 1; WriteReg = r; WriteData = d;
        tick();
        RegWrite = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        #3 rst = 1;
        tick(); tick();
        #2 rst = 0;
        tick();
        for (int a = 0; a < 32; a++) begin
            dbg_addr = a[4:0];
            #1 chk($sformatf("reset_dbg%0d", a), dbg_data, 32'h0);
        end
        // writes to $0 are discarded and never bypassed
        RegWrite = 1; WriteReg = 0; WriteData = 32'hDEADBEEF; rs = 0; rt = 0; dbg_addr = 0;
        #1 chk("zero_bypass_A", A, 32'h0);
        chk("zero_bypass_rt", rt_data, 32'h0);
        tick();
        RegWrite = 0;
        #1 chk("zero_dbg", dbg_data, 32'h0);
        chk("zero_A", A, 32'h0);
        // write then read
        wr(5, 32'h0000_0007);
        wr(6, 32'hFFFF_FFF9);
        rs = 5; rt = 6; ALUSrc = 0;
        #1 chk("rd_A", A, 32'h0000_0007);
        chk("rd_B", B, 32'hFFFF_FFF9);
        chk("rd_rt", rt_data, 32'hFFFF_FFF9);
        // bypass
        RegWrite = 1; WriteReg = 9; WriteData = 32'h1234_5678; rs = 9; rt = 9; dbg_addr = 9;
        #1 chk("byp_A", A, 32'h1234_5678);
        chk("byp_rt", rt_data, 32'h1234_5678);
        chk("byp_B", B, 32'h1234_5678);
        chk("byp_dbg_old", dbg_data, 32'h0);
        tick();
        RegWrite = 0;
        #1 chk("byp_A_stored", A, 32'h1234_5678);
        chk("byp_dbg_new", dbg_data, 32'h1234_5678);
        // immediate
        rt = 6; imm16 = 16'h8001; ExtOp = 1; ALUSrc = 1;
        #1 chk("imm_sext", B, 32'hFFFF_8001);
        chk("imm_sext_rt", rt_data, 32'hFFFF_FFF9);
        ExtOp = 0;
        #1 chk("imm_zext", B, 32'h0000_8001);
        chk("imm_zext_rt", rt_data, 32'hFFFF_FFF9);
        imm16 = 16'h7FFF; ExtOp = 1;
        #1 chk("imm_sext_pos", B, 32'h0000_7FFF);
        ALUSrc = 0;
        // reset mid-operation
        wr(3, 32'd5);
        dbg_addr = 3; rs = 3; rt = 5;
        #1 chk("mid_pre", dbg_data, 32'd5);
        RegWrite = 1; WriteReg = 3; WriteData = 32'd9;
        #1 rst = 1;
        #1 chk("mid_rst_dbg", dbg_data, 32'h0);
        chk("mid_rst_byp_A", A, 32'd9);
        chk("mid_rst_rt", rt_data, 32'h0);
        ALUSrc = 1;
        #1 chk("mid_rst_B_ext", B, 32'h0000_7FFF);
        ALUSrc = 0;
        tick();
        chk("mid_rst_edge", dbg_data, 32'h0);
        #2 rst = 0;
        tick();
        RegWrite = 0;
        #1 chk("mid_post", dbg_data, 32'd9);
        dbg_addr = 5;
        #1 chk("mid_post_5", dbg_data, 32'h0);
        // sweep
        for (int n = 1; n < 32; n++) wr(n[4:0], n * 32'h0101_0101);
        for (int a = 0; a < 32; a++) begin
            rs = a[4:0]; rt = a[4:0]; dbg_addr = a[4:0];
            #1;
            chk($sformatf("sw_A%0d", a), A, a * 32'h0101_0101);
            chk($sformatf("sw_rt%0d", a), rt_data, a * 32'h0101_0101);
            chk($sformatf("sw_dbg%0d", a), dbg_data, a * 32'h0101_0101);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
